// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The forwarding priority helper keeps both operand paths identical.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // The memory-stage result is younger, so it wins over writeback.
  function automatic logic [1:0] fwd_pick(input logic hit_m, input logic hit_w);
    if (hit_m)      return FWD_MEM;
    else if (hit_w) return FWD_WB;
    else            return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Used for the stall and flush performance counters.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard controller: forwarding selects, load-use stalls, redirect
// flushes, whole-pipeline freeze on data-memory wait, and a memory timeout.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REGISTER_ADDRESS_WIDTH = 5,
  parameter int COUNT_WIDTH            = 32,
  parameter int MEM_TIMEOUT            = 256,
  parameter int WAIT_WIDTH             = 9
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1D_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2D_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1E_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2E_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdE_i,
  input  logic                              ResultSrcE0_i,
  input  logic                              PCSrcE_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdM_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdW_i,
  input  logic                              RegWriteM_i,
  input  logic                              RegWriteW_i,
  input  logic                              MemReqM_i,
  input  logic                              MemReadyM_i,
  output logic                              StallF_o,
  output logic                              StallD_o,
  output logic                              StallE_o,
  output logic                              StallM_o,
  output logic                              FlushD_o,
  output logic                              FlushE_o,
  output logic                              FlushW_o,
  output logic [1:0]                        ForwardAE_o,
  output logic [1:0]                        ForwardBE_o,
  output logic                              MemTimeout_o,
  output logic [COUNT_WIDTH-1:0]            StallCount_o,
  output logic [COUNT_WIDTH-1:0]            FlushCount_o
);

  localparam logic [WAIT_WIDTH-1:0] WAIT_LAST = WAIT_WIDTH'(MEM_TIMEOUT - 1);

  logic mem_stall;
  logic lw_stall;

  assign mem_stall = MemReqM_i & ~MemReadyM_i;
  assign lw_stall  = ResultSrcE0_i & (RdE_i != '0) &
                     ((RdE_i == Rs1D_i) | (RdE_i == Rs2D_i));

  logic [1:0][REGISTER_ADDRESS_WIDTH-1:0] rs_e;
  logic [1:0][1:0]                        fwd_sel;

  assign rs_e[0] = Rs1E_i;
  assign rs_e[1] = Rs2E_i;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic hit_m;
    logic hit_w;
    assign hit_m = RegWriteM_i & (RdM_i != '0) & (RdM_i == rs_e[gi]);
    assign hit_w = RegWriteW_i & (RdW_i != '0) & (RdW_i == rs_e[gi]);
    assign fwd_sel[gi] = rst_i ? FWD_RF : fwd_pick(hit_m, hit_w);
  end

  assign ForwardAE_o = fwd_sel[0];
  assign ForwardBE_o = fwd_sel[1];

  // A memory freeze holds every stage and defers redirect flushes, since a
  // clear would otherwise override the hold on the same register.
  always_comb begin
    StallF_o = 1'b0;
    StallD_o = 1'b0;
    StallE_o = 1'b0;
    StallM_o = 1'b0;
    FlushD_o = 1'b0;
    FlushE_o = 1'b0;
    FlushW_o = 1'b0;
    if (rst_i) begin
      FlushD_o = 1'b1;
      FlushE_o = 1'b1;
      FlushW_o = 1'b1;
    end else if (mem_stall) begin
      StallF_o = 1'b1;
      StallD_o = 1'b1;
      StallE_o = 1'b1;
      StallM_o = 1'b1;
      FlushW_o = 1'b1;
    end else begin
      StallF_o = lw_stall;
      StallD_o = lw_stall;
      FlushD_o = PCSrcE_i;
      FlushE_o = lw_stall | PCSrcE_i;
    end
  end

  hz_state_t             state_reg;
  logic [WAIT_WIDTH-1:0] wait_cnt_reg;
  logic                  timeout_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= RUN;
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          if (mem_stall) begin
            state_reg    <= MEM_WAIT;
            wait_cnt_reg <= '0;
          end
        end
        MEM_WAIT: begin
          // Counter parks at the last value; the flag is sticky anyway.
          if (wait_cnt_reg == WAIT_LAST) begin
            timeout_reg <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
          if (MemReadyM_i || !MemReqM_i) begin
            state_reg <= RUN;
          end
        end
        default: state_reg <= RUN;
      endcase
    end
  end

  assign MemTimeout_o = timeout_reg;

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (StallF_o),
    .count (StallCount_o)
  );

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (FlushE_o),
    .count (FlushCount_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a default-size instance plus a small one
// (MEM_TIMEOUT=4, COUNT_WIDTH=2) for timeout and saturation, sharing stimulus.
module tb_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [4:0] Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i;
  logic       ResultSrcE0_i, PCSrcE_i, RegWriteM_i, RegWriteW_i;
  logic       MemReqM_i, MemReadyM_i;

  logic        StallF_o, StallD_o, StallE_o, StallM_o;
  logic        FlushD_o, FlushE_o, FlushW_o;
  logic [1:0]  ForwardAE_o, ForwardBE_o;
  logic        MemTimeout_o;
  logic [31:0] StallCount_o, FlushCount_o;

  logic        s_StallF, s_StallD, s_StallE, s_StallM;
  logic        s_FlushD, s_FlushE, s_FlushW;
  logic [1:0]  s_FwdA, s_FwdB;
  logic        s_Timeout;
  logic [1:0]  s_StallCount, s_FlushCount;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  hazard_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .Rs1D_i(Rs1D_i), .Rs2D_i(Rs2D_i), .Rs1E_i(Rs1E_i), .Rs2E_i(Rs2E_i),
    .RdE_i(RdE_i), .ResultSrcE0_i(ResultSrcE0_i), .PCSrcE_i(PCSrcE_i),
    .RdM_i(RdM_i), .RdW_i(RdW_i), .RegWriteM_i(RegWriteM_i), .RegWriteW_i(RegWriteW_i),
    .MemReqM_i(MemReqM_i), .MemReadyM_i(MemReadyM_i),
    .StallF_o(StallF_o), .StallD_o(StallD_o), .StallE_o(StallE_o), .StallM_o(StallM_o),
    .FlushD_o(FlushD_o), .FlushE_o(FlushE_o), .FlushW_o(FlushW_o),
    .ForwardAE_o(ForwardAE_o), .ForwardBE_o(ForwardBE_o),
    .MemTimeout_o(MemTimeout_o), .StallCount_o(StallCount_o), .FlushCount_o(FlushCount_o)
  );

  hazard_ctrl #(.COUNT_WIDTH(2), .MEM_TIMEOUT(4), .WAIT_WIDTH(3)) dut_s (
    .clk_i(clk_i), .rst_i(rst_i),
    .Rs1D_i(Rs1D_i), .Rs2D_i(Rs2D_i), .Rs1E_i(Rs1E_i), .Rs2E_i(Rs2E_i),
    .RdE_i(RdE_i), .ResultSrcE0_i(ResultSrcE0_i), .PCSrcE_i(PCSrcE_i),
    .RdM_i(RdM_i), .RdW_i(RdW_i), .RegWriteM_i(RegWriteM_i), .RegWriteW_i(RegWriteW_i),
    .MemReqM_i(MemReqM_i), .MemReadyM_i(MemReadyM_i),
    .StallF_o(s_StallF), .StallD_o(s_StallD), .StallE_o(s_StallE), .StallM_o(s_StallM),
    .FlushD_o(s_FlushD), .FlushE_o(s_FlushE), .FlushW_o(s_FlushW),
    .ForwardAE_o(s_FwdA), .ForwardBE_o(s_FwdB),
    .MemTimeout_o(s_Timeout), .StallCount_o(s_StallCount), .FlushCount_o(s_FlushCount)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic quiet();
    Rs1D_i = '0; Rs2D_i = '0; Rs1E_i = '0; Rs2E_i = '0;
    RdE_i = '0; RdM_i = '0; RdW_i = '0;
    ResultSrcE0_i = 0; PCSrcE_i = 0; RegWriteM_i = 0; RegWriteW_i = 0;
    MemReqM_i = 0; MemReadyM_i = 0;
  endtask

  // Checks all stall/flush outputs of the main instance as a packed vector
  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}.
  task automatic chk_ctl(input string tag, input logic [6:0] exp);
    chk(tag, {25'd0, StallF_o, StallD_o, StallE_o, StallM_o, FlushD_o, FlushE_o, FlushW_o},
        {25'd0, exp});
    $display("%s: ctl=%b", tag, {StallF_o, StallD_o, StallE_o, StallM_o, FlushD_o, FlushE_o, FlushW_o});
  endtask

  initial begin
    // Reset with hazards present on the inputs: they must all be masked.
    quiet();
    rst_i = 1;
    RdM_i = 5; RegWriteM_i = 1; Rs1E_i = 5; MemReqM_i = 1;
    #1;
    chk_ctl("reset_ctl", 7'b0000111);
    chk("reset_fwdA", ForwardAE_o, 0);
    step(); step();
    rst_i = 0;
    quiet();
    #1;
    chk("reset_stallcnt", StallCount_o, 0);
    chk("reset_flushcnt", FlushCount_o, 0);
    chk("reset_timeout", MemTimeout_o, 0);
    chk_ctl("idle_ctl", 7'b0000000);

    // Forwarding priority and register-0 suppression.
    RdM_i = 5; RegWriteM_i = 1; RdW_i = 5; RegWriteW_i = 1; Rs1E_i = 5; Rs2E_i = 5;
    #1; chk("fwdA_mem", ForwardAE_o, 2);
    RegWriteM_i = 0;
    #1; chk("fwdA_wb", ForwardAE_o, 1);
    chk("fwdB_wb", ForwardBE_o, 1);
    Rs1E_i = 0; RdM_i = 0; RegWriteM_i = 1;
    #1; chk("fwdA_x0", ForwardAE_o, 0);
    RdW_i = 0; Rs2E_i = 0;
    #1; chk("fwdB_x0", ForwardBE_o, 0);
    quiet();
    step();

    // Load to x0 never stalls.
    ResultSrcE0_i = 1; RdE_i = 0; Rs1D_i = 0;
    #1; chk_ctl("load_x0", 7'b0000000);
    quiet();
    step();

    // Load-use on Rs2D.
    ResultSrcE0_i = 1; RdE_i = 7; Rs2D_i = 7;
    #1; chk_ctl("loaduse", 7'b1100010);
    step(); quiet(); #1;
    chk("loaduse_stallcnt", StallCount_o, 1);
    chk("loaduse_flushcnt", FlushCount_o, 1);

    // Mispredict alone, then with a load-use hazard.
    PCSrcE_i = 1;
    #1; chk_ctl("mispredict", 7'b0000110);
    step(); quiet();
    PCSrcE_i = 1; ResultSrcE0_i = 1; RdE_i = 7; Rs1D_i = 7;
    #1; chk_ctl("mispred_lw", 7'b1100110);
    step(); quiet(); #1;
    chk("mispred_stallcnt", StallCount_o, 2);
    chk("mispred_flushcnt", FlushCount_o, 3);

    // Three-cycle memory wait with a redirect pending throughout.
    for (int i = 0; i < 3; i++) begin
      MemReqM_i = 1; MemReadyM_i = 0; PCSrcE_i = 1;
      #1; chk_ctl($sformatf("memwait_%0d", i), 7'b1111001);
      step();
    end
    MemReadyM_i = 1;
    #1; chk_ctl("memdone", 7'b0000110);
    step(); quiet(); #1;
    chk("mem_stallcnt", StallCount_o, 5);
    chk("mem_flushcnt", FlushCount_o, 4);
    chk("sat_stallcnt", s_StallCount, 3);
    chk("sat_flushcnt", s_FlushCount, 3);
    chk("small_timeout_short", s_Timeout, 0);
    chk("main_timeout_short", MemTimeout_o, 0);

    // Timeout on the small instance: flag visible after the fifth edge.
    MemReqM_i = 1; MemReadyM_i = 0;
    for (int i = 0; i < 4; i++) step();
    chk("timeout_early", s_Timeout, 0);
    step();
    chk("timeout_set", s_Timeout, 1);
    chk("timeout_main", MemTimeout_o, 0);
    MemReadyM_i = 1;
    step(); quiet(); step();
    chk("timeout_sticky", s_Timeout, 1);
    chk("timeout_stallcnt", StallCount_o, 10);

    // Reset in the middle of a wait aborts it.
    MemReqM_i = 1; MemReadyM_i = 0;
    step(); step();
    rst_i = 1;
    #1; chk_ctl("rst_midwait", 7'b0000111);
    step();
    rst_i = 0; quiet();
    #1;
    chk_ctl("after_rst", 7'b0000000);
    chk("after_rst_stallcnt", StallCount_o, 0);
    chk("after_rst_flushcnt", FlushCount_o, 0);
    chk("after_rst_timeout", s_Timeout, 0);
    step();
    chk_ctl("after_rst_idle", 7'b0000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
